// File: rtl/arb_pkg.sv
// Definitions shared by the round-robin arbiter and its requester agents.
package arb_pkg;

  localparam int N_CLIENTS    = 8;
  localparam int CLIENT_IDX_W = 3;

  typedef logic [N_CLIENTS-1:0] gnt_vec_t;

  // True when exactly one grant bit is set.
  function automatic logic gnt_is_onehot(input gnt_vec_t v);
    return (v != '0) && ((v & (v - gnt_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Synchronous FIFO holding the requester's outgoing words.
// The head is read combinationally from the registered storage.
// Flush has priority over push and pop.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [LW-1:0] level,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (level_q < LW'(DEPTH)) && !flush;
  assign do_pop  = pop && (level_q != '0);

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset because the level guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for one port of the 8-way round-robin arbiter.
// It requests only for words not already covered by the grant in hand,
// turns each one-cycle grant into one bus transfer, and flags starvation
// and grants that arrive with nothing to send.
module arb_requester
  import arb_pkg::*;
#(
  parameter  int DW           = 8,
  parameter  int DEPTH        = 4,
  parameter  int STARVE_LIMIT = 64,
  localparam int LW           = $clog2(DEPTH) + 1,
  localparam int WW           = $clog2(STARVE_LIMIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          req,
  input  logic          gnt,
  output logic          bus_valid,
  output logic [DW-1:0] bus_data,
  output logic [LW-1:0] level,
  output logic          starve,
  output logic          gnt_err
);

  logic [DW-1:0] head;
  logic          push;
  logic          pop;
  logic          flush_shadow_q;
  logic          starve_q, starve_d;
  logic          gnt_err_q, gnt_err_d;
  logic [WW-1:0] wd_q, wd_d;

  // No bypass: a full FIFO refuses input even while a word leaves.
  assign in_ready = level < LW'(DEPTH);
  assign push     = in_valid && in_ready;

  // A grant in the cycle after a flush belongs to words that no longer exist.
  assign pop       = gnt && (level != '0) && !flush_shadow_q;
  assign bus_valid = pop;
  assign bus_data  = pop ? head : '0;

  // Do not request for the word leaving this cycle.
  assign req = (level > LW'(pop)) && !flush;

  arb_req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .flush     (flush),
    .level     (level),
    .head      (head)
  );

  // Watchdog and sticky error flags; the counter saturates at STARVE_LIMIT-1.
  always_comb begin
    wd_d      = wd_q;
    starve_d  = starve_q;
    gnt_err_d = gnt_err_q;
    if (flush || gnt || !req) begin
      wd_d = '0;
    end else if (wd_q == WW'(STARVE_LIMIT - 1)) begin
      starve_d = 1'b1;
    end else begin
      wd_d = wd_q + WW'(1);
    end
    if (gnt && (level == '0) && !flush_shadow_q) gnt_err_d = 1'b1;
  end

  // Status and flush-shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_shadow_q <= 1'b0;
      starve_q       <= 1'b0;
      gnt_err_q      <= 1'b0;
      wd_q           <= '0;
    end else begin
      flush_shadow_q <= flush;
      starve_q       <= starve_d;
      gnt_err_q      <= gnt_err_d;
      wd_q           <= wd_d;
    end
  end

  assign starve  = starve_q;
  assign gnt_err = gnt_err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester (DEPTH=4, STARVE_LIMIT=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2 units later.
module tb_arb_requester;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SL    = 8;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          req;
  logic          gnt;
  logic          bus_valid;
  logic [DW-1:0] bus_data;
  logic [LW-1:0] level;
  logic          starve;
  logic          gnt_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_requester #(
    .DW           (DW),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .req       (req),
    .gnt       (gnt),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .level     (level),
    .starve    (starve),
    .gnt_err   (gnt_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    gnt      = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b want 0", bus_valid); end
    checks++; if (bus_data !== 8'h00) begin errors++; $display("FAIL reset_bus_data: got %h want 00", bus_data); end
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b want 0", starve); end
    checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL reset_gnt_err: got %b want 0", gnt_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_word();
    do_reset();
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL single_req_c0: got %b want 1", req); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level_c0: got %0d want 1", level); end
    step();
    gnt = 1'b1;
    #1;
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL single_bus_valid: got %b want 1", bus_valid); end
    checks++; if (bus_data !== 8'hA5) begin errors++; $display("FAIL single_bus_data: got %h want a5", bus_data); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_req_c1: got %b want 0", req); end
    step();
    gnt = 1'b0;
    #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_c2: got %0d want 0", level); end
    checks++; if (bus_data !== 8'h00) begin errors++; $display("FAIL single_bus_idle: got %h want 00", bus_data); end
    checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL single_gnt_err: got %b want 0", gnt_err); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1);
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d want 4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL fill_req: got %b want 1", req); end
    for (int i = 0; i < 4; i++) begin
      gnt = 1'b1;
      #1;
      checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL drain_bus_valid[%0d]: got %b want 1", i, bus_valid); end
      checks++; if (bus_data !== 8'(i + 1)) begin errors++; $display("FAIL drain_bus_data[%0d]: got %h want %h", i, bus_data, 8'(i + 1)); end
      checks++; if (req !== (i != 3)) begin errors++; $display("FAIL drain_req[%0d]: got %b want %b", i, req, (i != 3)); end
      if (i == 0) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_no_bypass: got %b want 0", in_ready); end
      end
      step();
      gnt = 1'b0;
      #1;
      checks++; if (level !== 3'(3 - i)) begin errors++; $display("FAIL drain_level[%0d]: got %0d want %0d", i, level, 3 - i); end
      step();
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    in_valid = 1'b1; in_data = 8'h11;
    step();
    in_data = 8'h22; gnt = 1'b1;
    #1;
    checks++; if (bus_data !== 8'h11) begin errors++; $display("FAIL pushpop_bus_data: got %h want 11", bus_data); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL pushpop_req: got %b want 0", req); end
    step();
    in_valid = 1'b0; gnt = 1'b0;
    #1;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL pushpop_level: got %0d want 1", level); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL pushpop_req_after: got %b want 1", req); end
    gnt = 1'b1;
    #1;
    checks++; if (bus_data !== 8'h22) begin errors++; $display("FAIL pushpop_bus_data2: got %h want 22", bus_data); end
    step();
    gnt = 1'b0;
    #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL pushpop_level_end: got %0d want 0", level); end
  endtask

  task automatic test_stray_grant();
    do_reset();
    gnt = 1'b1;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL stray_bus_valid: got %b want 0", bus_valid); end
    step();
    gnt = 1'b0;
    #1;
    checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL stray_gnt_err: got %b want 1", gnt_err); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL stray_level: got %0d want 0", level); end
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0; gnt = 1'b1;
    #1;
    checks++; if (bus_data !== 8'h5A) begin errors++; $display("FAIL stray_traffic_data: got %h want 5a", bus_data); end
    step();
    gnt = 1'b0;
    #1;
    checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b want 1", gnt_err); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h31; step();
    in_data = 8'h32; step();
    in_data = 8'h33; step();
    // flush cycle: a push is offered, a grant already issued is honoured
    in_data = 8'h77; flush = 1'b1; gnt = 1'b1;
    #1;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_level_k: got %0d want 3", level); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL flush_req_k: got %b want 0", req); end
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL flush_pop_k: got %b want 1", bus_valid); end
    checks++; if (bus_data !== 8'h31) begin errors++; $display("FAIL flush_data_k: got %h want 31", bus_data); end
    step();
    flush = 1'b0; in_valid = 1'b0; gnt = 1'b1;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL flush_shadow_bus: got %b want 0", bus_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level_k1: got %0d want 0", level); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL flush_req_k1: got %b want 0", req); end
    step();
    gnt = 1'b0;
    #1;
    checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL flush_gnt_err: got %b want 0", gnt_err); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level_end: got %0d want 0", level); end
  endtask

  task automatic test_starve();
    do_reset();
    in_valid = 1'b1; in_data = 8'h9C;
    step();
    in_valid = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      #1;
      if (c != 7) begin
        checks++;
        if (starve !== (c >= 8)) begin errors++; $display("FAIL starve_c%0d: got %b want %b", c, starve, (c >= 8)); end
      end
      step();
    end
    gnt = 1'b1;
    #1;
    checks++; if (bus_data !== 8'h9C) begin errors++; $display("FAIL starve_late_pop: got %h want 9c", bus_data); end
    step();
    gnt = 1'b0;
    #1;
    checks++; if (starve !== 1'b1) begin errors++; $display("FAIL starve_sticky: got %b want 1", starve); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL starve_level: got %0d want 0", level); end
  endtask

  // Continues from the starvation scenario so the sticky flags start set.
  task automatic test_async_reset();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    #1;
    checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL arst_pre_gnt_err: got %b want 1", gnt_err); end
    in_valid = 1'b1;
    in_data = 8'h41; step();
    in_data = 8'h42; step();
    in_valid = 1'b0;
    #1;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL arst_pre_level: got %0d want 2", level); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL arst_pre_req: got %b want 1", req); end
    gnt = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b want 0", req); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL arst_bus_valid: got %b want 0", bus_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level: got %0d want 0", level); end
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL arst_starve: got %b want 0", starve); end
    checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL arst_gnt_err: got %b want 0", gnt_err); end
    gnt = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL arst_req_after: got %b want 0", req); end
    in_valid = 1'b1; in_data = 8'h43;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL arst_req_new_push: got %b want 1", req); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_drain();
    test_push_pop();
    test_stray_grant();
    test_flush();
    test_starve();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
